// File: rtl/fta_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : fta_issue_seq
// Purpose  : Issue/response sequencer for the fault-tolerant 3-bit adder.
//            Encodes operands into the protected input code, waits for the
//            result to settle, retries on a two-rail error and returns it.
//            Optional fault injection: define FTA_FAULT_INJECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fta_issue_seq #(
    parameter int SETTLE_CYC = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [2:0] req_a,
    input  logic [2:0] req_b,
`ifdef FTA_FAULT_INJECT_EN
    input  logic [1:0] inj_mode,
`endif
    output logic [2:0] opd_a,
    output logic [2:0] opd_b,
    output logic       opd_par,
    output logic [2:0] opd_code,
    input  logic [2:0] res_sum,
    input  logic       res_cout,
    input  logic       res_e0,
    input  logic       res_e1,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_sum,
    output logic       rsp_cout,
    output logic [1:0] rsp_status,
    output logic [2:0] rsp_retries
);

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYC - 1);
    localparam logic [2:0] c_max_retry   = 3'(MAX_RETRY);
    localparam logic [1:0] c_op_add      = 2'b00;
    localparam logic [1:0] c_op_sub      = 2'b01;
    localparam logic [1:0] c_op_ill      = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       w_accept;
    logic       w_good;
    logic [3:0] r_settle;
    logic [2:0] r_retries;
    logic [2:0] w_enc_code;
    logic       w_enc_par;
`ifdef FTA_FAULT_INJECT_EN
    logic [1:0] r_inj;
`endif

    // The two rails disagree exactly when the adder judged its own result sound.
    assign w_good = res_e0 ^ res_e1;

    always_comb begin
        w_enc_par = ~(^{req_a, req_b});
        case (req_op)
            c_op_add: w_enc_code = 3'b001;
            c_op_sub: w_enc_code = 3'b010;
            default:  w_enc_code = 3'b100;
        endcase
`ifdef FTA_FAULT_INJECT_EN
        if (inj_mode == 2'b01 || inj_mode == 2'b11)
            w_enc_par = ~w_enc_par;
        if (inj_mode == 2'b10)
            w_enc_code = 3'b011;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = (req_op == c_op_ill) ? S_RESP : S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_settle == c_settle_last)
                    w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_good || r_retries == c_max_retry)
                    w_state_next = S_RESP;
                else
                    w_state_next = S_DRIVE;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opd_a       <= 3'b000;
            opd_b       <= 3'b000;
            opd_par     <= 1'b1;
            opd_code    <= 3'b001;
            rsp_sum     <= 3'b000;
            rsp_cout    <= 1'b0;
            rsp_status  <= 2'b00;
            rsp_retries <= 3'b000;
            r_settle    <= 4'd0;
            r_retries   <= 3'd0;
`ifdef FTA_FAULT_INJECT_EN
            r_inj       <= 2'b00;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_settle  <= 4'd0;
                    r_retries <= 3'd0;
                    if (w_accept) begin
                        if (req_op == c_op_ill) begin
                            rsp_sum     <= 3'b000;
                            rsp_cout    <= 1'b0;
                            rsp_status  <= 2'b11;
                            rsp_retries <= 3'b000;
                        end else begin
                            opd_a    <= req_a;
                            opd_b    <= req_b;
                            opd_par  <= w_enc_par;
                            opd_code <= w_enc_code;
`ifdef FTA_FAULT_INJECT_EN
                            r_inj    <= inj_mode;
`endif
                        end
                    end
                end
                S_DRIVE: begin
                    if (r_settle != c_settle_last)
                        r_settle <= r_settle + 4'd1;
                end
                S_CHECK: begin
                    r_settle    <= 4'd0;
                    rsp_sum     <= res_sum;
                    rsp_cout    <= res_cout;
                    rsp_retries <= r_retries;
                    if (w_good) begin
                        rsp_status <= (r_retries == 3'd0) ? 2'b00 : 2'b01;
                    end else if (r_retries == c_max_retry) begin
                        rsp_status <= 2'b10;
                    end else begin
                        r_retries <= r_retries + 3'd1;
`ifdef FTA_FAULT_INJECT_EN
                        // One-shot parity fault: restore the clean parity for the re-issue.
                        if (r_inj == 2'b11) begin
                            opd_par <= ~opd_par;
                            r_inj   <= 2'b00;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
